striping: RTL
=============

# striping

Two-lane word striper in the physical-layer datapath, directly upstream of `un_striping`. It accepts a 32-bit word stream at the `clk_2f` rate and distributes consecutive words alternately onto `lane_0` and `lane_1`. Each lane word is held for two `clk_2f` cycles, which gives each lane an effective `clk_f` rate. Lane outputs are timed so that `un_striping` can reconstruct the original stream unchanged.

## Interface
- `DATA_WIDTH`, 32, width of stream words and lane words.
- `clk_2f`  in  1  sole clock; all state is updated on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `data_in`  in  DATA_WIDTH  input stream word.
- `valid_in`  in  1  `data_in` is valid this cycle; every valid word is accepted, with no backpressure.
- `lane_0`  out  DATA_WIDTH  even-word lane.
- `valid_0`  out  1  `lane_0` holds a valid word.
- `lane_1`  out  DATA_WIDTH  odd-word lane.
- `valid_1`  out  1  `lane_1` holds a valid word.
- `next_lane`  out  1  lane that receives the next accepted word (0 or 1).
- `busy`  out  1  high when either lane is valid.

## Operation
- Reset values: all outputs are 0, FSM is in IDLE, and both hold counters are 0.
- FSM states and the lane each one selects:
  - IDLE: `next_lane`=0.
  - EVEN: `next_lane`=0.
  - ODD: `next_lane`=1.
- FSM transitions:
  - IDLE or EVEN, `valid_in`=1 → ODD.
  - ODD, `valid_in`=1 → EVEN.
  - EVEN or ODD, `valid_in`=0 with both lane hold counters about to reach 0 → IDLE.
  - After a gap of exactly one idle cycle, the selector is preserved. After two or more idle cycles, it returns to lane 0.
- Lane capture on an accepted word:
  - Lane `next_lane` loads `data_in`.
  - Its valid is set to 1 and its hold counter to 2.
- Lane aging: in any cycle a lane is not loaded, its hold counter decrements if it is nonzero. When the counter goes 1 → 0, that lane's valid and data clear to 0 on the same edge.
- Continuous streaming: each lane is reloaded every 2 cycles, so both valids stay high continuously once the pipe is full.
- Odd-length burst: the final word sits on `lane_0` for 2 cycles. `lane_1` drains independently.
- Load and expiry on the same edge: the load wins, and the counter is set to 2.
- `busy` is `valid_0 | valid_1`, registered consistently with the valids.
- An asynchronous reset mid-burst clears everything immediately. Words in flight are dropped and not replayed. The first word after reset goes to `lane_0`.

## Timing
- Latency: `data_in` sampled at edge N appears on the selected lane after edge N, i.e. 1 cycle.
- The lanes update on alternating cycles, offset by one `clk_2f` cycle (`lane_0` first), which matches the skew `un_striping` expects.
- There is no combinational path from inputs to outputs; all outputs are registers.
- `next_lane` is decoded from the registered state.

## Structure
- The shared package `striping_pkg` holds:
  - the `DATA_WIDTH` default;
  - the state enum IDLE/EVEN/ODD;
  - the hold-count constant `HOLD_CYCLES`=2.
- One sub-module, `striping_lane_reg`, instantiated twice. It contains:
  - the data register;
  - the valid flag;
  - the 2-bit hold counter.
  - Inputs: `load`, `din`. Outputs: `lane`, `valid`.
- The top level contains the FSM, lane select, and `busy`.

## Test plan
- **Reset:** assert `reset` asynchronously between edges → all outputs read 0 immediately, before the next edge.
- **Burst of four words** (FFFFFFFF, EEEEEEEE, DDDDDDDD, CCCCCCCC), one per cycle, edges 1–4:
  - `lane_0`=FFFFFFFF after edge 1.
  - `lane_1`=EEEEEEEE after edge 2.
  - `lane_0`=DDDDDDDD after edge 3.
  - `lane_1`=CCCCCCCC after edge 4.
  - `valid_0` drops after edge 5 and `valid_1` after edge 6, with data 0 when each valid drops.
- **Odd burst, then idle:** send 00000003 alone → `valid_0`=1 for exactly 2 cycles and `valid_1` stays 0. After 2 idle cycles, the next word 00000004 goes to `lane_0`.
- **Single-cycle gap:** send A, idle, B → A goes to `lane_0` and B to `lane_1`, with `next_lane`=1 during the gap.
- **Reset mid-stream:** assert reset while `lane_1`=EEEEEEEE is valid → everything clears. The first word after release goes to `lane_0`.
- **Loopback with `un_striping`:** drive 64 random words with random single and double gaps → the `un_striping` output sequence equals the input sequence word-for-word, with no drops or duplicates.

Source files
------------

// File: rtl/striping_pkg.sv
// Shared types and constants for the two-lane word striper.
// Holds the default word width, FSM state enum and lane hold time.
package striping_pkg;

  localparam int DATA_WIDTH = 32;

  localparam logic [1:0] HOLD_CYCLES = 2'd2;

  typedef enum logic [1:0] {
    IDLE,
    EVEN,
    ODD
  } state_t;

endpackage

// File: rtl/striping_lane_reg.sv
// One output lane: data word, valid flag and 2-bit hold counter.
// Ports: clk_2f, reset, load, din in; lane, valid, hold_low out.
module striping_lane_reg
  import striping_pkg::*;
#(
  parameter int DATA_WIDTH = striping_pkg::DATA_WIDTH
) (
  input  logic                  clk_2f,
  input  logic                  reset,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] lane,
  output logic                  valid,
  output logic                  hold_low
);

  logic [1:0] cnt;

  always_ff @(posedge clk_2f or posedge reset) begin
    if (reset) begin
      lane  <= '0;
      valid <= 1'b0;
      cnt   <= 2'd0;
    end else if (load) begin
      lane  <= din;
      valid <= 1'b1;
      cnt   <= HOLD_CYCLES;
    end else if (cnt != 2'd0) begin
      cnt <= cnt - 2'd1;
      if (cnt == 2'd1) begin
        lane  <= '0;
        valid <= 1'b0;
      end
    end
  end

  // Counter will be zero after the next edge unless reloaded.
  assign hold_low = (cnt <= 2'd1);

endmodule

// File: rtl/striping.sv
// Two-lane word striper: alternates accepted words onto lane_0/lane_1.
// Ports: clk_2f, reset, data_in, valid_in in; lanes, valids, next_lane, busy out.
module striping
  import striping_pkg::*;
#(
  parameter int DATA_WIDTH = striping_pkg::DATA_WIDTH
) (
  input  logic                  clk_2f,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  valid_in,
  output logic [DATA_WIDTH-1:0] lane_0,
  output logic                  valid_0,
  output logic [DATA_WIDTH-1:0] lane_1,
  output logic                  valid_1,
  output logic                  next_lane,
  output logic                  busy
);

  state_t state_q;
  state_t state_d;
  logic   low_0;
  logic   low_1;
  logic   drain;
  logic   load_0;
  logic   load_1;

  assign next_lane = (state_q == ODD);
  assign load_0    = valid_in & ~next_lane;
  assign load_1    = valid_in & next_lane;

  // Both lanes empty after this edge: a second idle cycle,
  // so the selector falls back to lane 0.
  assign drain = low_0 & low_1;

  always_ff @(posedge clk_2f or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (valid_in) state_d = ODD;
      end
      EVEN: begin
        if (valid_in)   state_d = ODD;
        else if (drain) state_d = IDLE;
      end
      ODD: begin
        if (valid_in)   state_d = EVEN;
        else if (drain) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  striping_lane_reg #(.DATA_WIDTH(DATA_WIDTH)) u_lane_0 (
    .clk_2f   (clk_2f),
    .reset    (reset),
    .load     (load_0),
    .din      (data_in),
    .lane     (lane_0),
    .valid    (valid_0),
    .hold_low (low_0)
  );

  striping_lane_reg #(.DATA_WIDTH(DATA_WIDTH)) u_lane_1 (
    .clk_2f   (clk_2f),
    .reset    (reset),
    .load     (load_1),
    .din      (data_in),
    .lane     (lane_1),
    .valid    (valid_1),
    .hold_low (low_1)
  );

  assign busy = valid_0 | valid_1;

endmodule
